// File: rtl/gcd_stein.sv
// Binary (Stein) GCD: one reduction step per clock, zero operands flagged as an error.
// Optional CYCLES step counter is built when GCD_STEIN_CYCLES_EN is defined.
module gcd_stein #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             START,
   output logic [WIDTH-1:0] Y,
   output logic             DONE,
   output logic             ERROR,
`ifdef GCD_STEIN_CYCLES_EN
   output logic [$clog2(2*WIDTH+2)-1:0] CYCLES,
`endif
   output logic             BUSY
);

   // state  | meaning
   // IDLE   | waiting for START; Y/ERROR hold the last result
   // CALC   | one binary-GCD step per cycle until a==b
   // FINISH | single-cycle DONE pulse, then back to IDLE

   localparam int KW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a, b, a_nxt, b_nxt, y_nxt;
   logic [KW-1:0]    k, k_nxt;
   logic             err_nxt, done_nxt;

`ifdef GCD_STEIN_CYCLES_EN
   localparam int CW = $clog2(2*WIDTH+2);
   logic [CW-1:0] cyc, cyc_nxt;
   assign CYCLES = cyc;
`endif

   assign BUSY = (state != IDLE);

   always_comb begin
      state_nxt = state;
      a_nxt     = a;
      b_nxt     = b;
      k_nxt     = k;
      y_nxt     = Y;
      err_nxt   = ERROR;
`ifdef GCD_STEIN_CYCLES_EN
      cyc_nxt   = cyc;
`endif
      case (state)
         IDLE: begin
            if (START) begin
               a_nxt = A;
               b_nxt = B;
               k_nxt = '0;
`ifdef GCD_STEIN_CYCLES_EN
               cyc_nxt = '0;
`endif
               if (A == '0 || B == '0) begin
                  state_nxt = FINISH;
                  err_nxt   = 1'b1;
                  y_nxt     = '0;
               end else begin
                  state_nxt = CALC;
                  err_nxt   = 1'b0;
               end
            end
         end
         CALC: begin
`ifdef GCD_STEIN_CYCLES_EN
            cyc_nxt = cyc + CW'(1);
`endif
            if (a == b) begin
               // k only counts common factors of two, so the shift cannot overflow
               y_nxt     = a << k;
               state_nxt = FINISH;
            end else if (!a[0] && !b[0]) begin
               a_nxt = a >> 1;
               b_nxt = b >> 1;
               k_nxt = k + KW'(1);
            end else if (!a[0]) begin
               a_nxt = a >> 1;
            end else if (!b[0]) begin
               b_nxt = b >> 1;
            end else if (a > b) begin
               a_nxt = (a - b) >> 1;
            end else begin
               b_nxt = (b - a) >> 1;
            end
         end
         FINISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      done_nxt = (state_nxt == FINISH);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         a     <= '0;
         b     <= '0;
         k     <= '0;
         Y     <= '0;
         ERROR <= 1'b0;
         DONE  <= 1'b0;
`ifdef GCD_STEIN_CYCLES_EN
         cyc   <= '0;
`endif
      end else begin
         state <= state_nxt;
         a     <= a_nxt;
         b     <= b_nxt;
         k     <= k_nxt;
         Y     <= y_nxt;
         ERROR <= err_nxt;
         DONE  <= done_nxt;
`ifdef GCD_STEIN_CYCLES_EN
         cyc   <= cyc_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_gcd_stein.sv
// Directed vector bench for gcd_stein: 8-bit vector table plus hand-written
// back-to-back, reset-abort and 16-bit sequences.
module tb_gcd_stein;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0, y8;
   logic        start8 = 1'b0, done8, err8, busy8;
   logic [15:0] a16 = '0, b16 = '0, y16;
   logic        start16 = 1'b0, done16, err16, busy16;
`ifdef GCD_STEIN_CYCLES_EN
   logic [4:0]  cyc8;
   logic [5:0]  cyc16;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   gcd_stein #(.WIDTH(8)) dut8 (
      .CLK(clk), .RST_N(rst_n), .A(a8), .B(b8), .START(start8),
      .Y(y8), .DONE(done8), .ERROR(err8),
`ifdef GCD_STEIN_CYCLES_EN
      .CYCLES(cyc8),
`endif
      .BUSY(busy8)
   );

   gcd_stein #(.WIDTH(16)) dut16 (
      .CLK(clk), .RST_N(rst_n), .A(a16), .B(b16), .START(start16),
      .Y(y16), .DONE(done16), .ERROR(err16),
`ifdef GCD_STEIN_CYCLES_EN
      .CYCLES(cyc16),
`endif
      .BUSY(busy16)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic       err;
      int         busy;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Pulse START with the given operands, then watch until DONE (bounded).
   task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] yo, output logic eo,
                       output int busy_n, output int cyc_o, output bit to);
      @(negedge clk);
      a8 = av; b8 = bv; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      busy_n = 0; to = 1'b1; yo = '0; eo = 1'b0; cyc_o = -1;
      for (int i = 0; i < 100; i++) begin
         if (busy8) busy_n++;
         if (done8) begin
            yo = y8; eo = err8; to = 1'b0;
`ifdef GCD_STEIN_CYCLES_EN
            cyc_o = int'(cyc8);
`endif
            break;
         end
         @(negedge clk);
      end
      if (to) begin
         total++;
         $display("FAIL run8 timeout: no DONE within 100 cycles for A=%0d B=%0d", av, bv);
      end
   endtask

   initial begin
      logic [7:0] yo;
      logic       eo;
      int         bn, co, cnt, seen;
      bit         to;

      vecs[0]  = '{8'd12,  8'd8,   8'd4,   1'b0, 6};
      vecs[1]  = '{8'd0,   8'd5,   8'd0,   1'b1, 1};
      vecs[2]  = '{8'd255, 8'd255, 8'd255, 1'b0, 2};
      vecs[3]  = '{8'd5,   8'd0,   8'd0,   1'b1, 1};
      vecs[4]  = '{8'd1,   8'd1,   8'd1,   1'b0, 2};
      vecs[5]  = '{8'd48,  8'd18,  8'd6,   1'b0, 7};
      vecs[6]  = '{8'd0,   8'd0,   8'd0,   1'b1, 1};
      vecs[7]  = '{8'd7,   8'd13,  8'd1,   1'b0, 6};
      vecs[8]  = '{8'd128, 8'd64,  8'd64,  1'b0, 9};
      vecs[9]  = '{8'd1,   8'd255, 8'd1,   1'b0, 9};
      vecs[10] = '{8'd21,  8'd14,  8'd7,   1'b0, 4};

      // reset state
      repeat (2) @(negedge clk);
      chk("reset Y", y8, 0);
      chk("reset DONE", done8, 0);
      chk("reset ERROR", err8, 0);
      chk("reset BUSY", busy8, 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run8(vecs[i].a, vecs[i].b, yo, eo, bn, co, to);
         if (!to) begin
            chk($sformatf("vec%0d Y", i), yo, vecs[i].y);
            chk($sformatf("vec%0d ERROR", i), eo, vecs[i].err);
            chk($sformatf("vec%0d busy cycles", i), bn, vecs[i].busy);
`ifdef GCD_STEIN_CYCLES_EN
            chk($sformatf("vec%0d CYCLES", i), co, vecs[i].err ? 0 : vecs[i].busy - 1);
`endif
            @(negedge clk);
            chk($sformatf("vec%0d DONE one cycle", i), done8, 0);
            chk($sformatf("vec%0d idle BUSY", i), busy8, 0);
            a8 = 8'd99; b8 = 8'd33;
            @(negedge clk);
            chk($sformatf("vec%0d Y hold", i), y8, vecs[i].y);
            chk($sformatf("vec%0d ERROR hold", i), err8, vecs[i].err);
         end
      end

      // START held high, operands changed while busy
      @(negedge clk);
      a8 = 8'd12; b8 = 8'd8; start8 = 1'b1;
      @(negedge clk);
      a8 = 8'd21; b8 = 8'd14;
      to = 1'b1; bn = 0;
      for (int i = 0; i < 100; i++) begin
         if (busy8) bn++;
         if (done8) begin to = 1'b0; break; end
         @(negedge clk);
      end
      if (to) begin total++; $display("FAIL held-start first run: timeout"); end
      chk("held first Y", y8, 4);
      chk("held first busy", bn, 6);
      @(negedge clk);
      chk("held idle gap BUSY", busy8, 0);
      chk("held idle gap DONE", done8, 0);
      @(negedge clk);
      chk("held second start BUSY", busy8, 1);
      start8 = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (done8) begin to = 1'b0; break; end
         @(negedge clk);
      end
      if (to) begin total++; $display("FAIL held-start second run: timeout"); end
      chk("held second Y", y8, 7);
      chk("held second ERROR", err8, 0);

      // reset on the third CALC cycle
      @(negedge clk);
      a8 = 8'd12; b8 = 8'd8; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      seen = 0;
      for (cnt = 1; cnt < 3; cnt++) begin
         if (done8) seen++;
         @(negedge clk);
      end
      if (done8) seen++;
      chk("abort pre-reset BUSY", busy8, 1);
      rst_n = 1'b0;
      #1;
      chk("abort Y", y8, 0);
      chk("abort DONE", done8, 0);
      chk("abort ERROR", err8, 0);
      chk("abort BUSY", busy8, 0);
      repeat (2) begin
         @(negedge clk);
         if (done8) seen++;
      end
      chk("abort no DONE", seen, 0);
      rst_n = 1'b1;
      run8(8'd21, 8'd14, yo, eo, bn, co, to);
      if (!to) begin
         chk("post-reset Y", yo, 7);
         chk("post-reset busy", bn, 4);
      end

      // 16-bit worst-ish case: 65535 with 1
      @(negedge clk);
      a16 = 16'hFFFF; b16 = 16'd1; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      to = 1'b1; bn = 0;
      for (int i = 0; i < 100; i++) begin
         if (busy16) bn++;
         if (done16) begin to = 1'b0; break; end
         @(negedge clk);
      end
      if (to) begin total++; $display("FAIL w16 run: timeout"); end
      chk("w16 Y", y16, 1);
      chk("w16 ERROR", err16, 0);
      chk("w16 busy", bn, 17);
`ifdef GCD_STEIN_CYCLES_EN
      chk("w16 CYCLES", cyc16, 16);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
